// File: rtl/object_motion_if.sv
// Button, vSync and position bundle between the game logic and its environment.
interface object_motion_if;
  logic       vSync;
  logic       btnUp;
  logic       btnDown;
  logic [9:0] playerX;
  logic [9:0] playerY;
  logic [9:0] obsX;
  logic [9:0] obsY;
  logic       hit;
  logic       frameTick;

  modport master (
    output vSync, btnUp, btnDown,
    input  playerX, playerY, obsX, obsY, hit, frameTick
  );

  modport slave (
    input  vSync, btnUp, btnDown,
    output playerX, playerY, obsX, obsY, hit, frameTick
  );
endinterface

// File: rtl/object_motion.sv
// Per-frame player/obstacle motion with collision FSM (PLAY/HIT).
// Define AUTO_RESTART_EN to leave HIT after HIT_FRAMES frame ticks.
module object_motion #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int PLAYER_X   = 200,
  parameter int PLAYER_W   = 40,
  parameter int PLAYER_H   = 40,
  parameter int OBS_W      = 20,
  parameter int OBS_H      = 80,
  parameter int P_STEP     = 2,
  parameter int O_STEP     = 4,
  parameter int HIT_FRAMES = 120
) (
  input logic           clock,
  input logic           clear,
  object_motion_if.slave bus
);

  localparam logic [9:0] PX     = 10'(PLAYER_X);
  localparam logic [9:0] PW     = 10'(PLAYER_W);
  localparam logic [9:0] PH     = 10'(PLAYER_H);
  localparam logic [9:0] OW     = 10'(OBS_W);
  localparam logic [9:0] OH     = 10'(OBS_H);
  localparam logic [9:0] OY     = 10'd100;
  localparam logic [9:0] PSTEP  = 10'(P_STEP);
  localparam logic [9:0] OSTEP  = 10'(O_STEP);
  localparam logic [9:0] PY_MAX = 10'(SCREEN_H - PLAYER_H);
  localparam logic [9:0] OX_RLD = 10'(SCREEN_W - OBS_W);
  localparam logic [9:0] PY_RST = 10'd200;
  localparam logic [9:0] OX_RST = 10'd400;

  typedef enum logic {PLAY, HIT} state_t;

  logic   up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
  logic   vs_q, vs_prev_q;
  logic   tick_q, tick_d;
  state_t state_q, state_d;
  logic   hit_q, hit_d;
  logic [9:0] py_q, py_d;
  logic [9:0] ox_q, ox_d;
  logic   overlap;

`ifdef AUTO_RESTART_EN
  localparam int CW = $clog2(HIT_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HIT_FRAMES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Strict overlap: touching edges are not a collision.
  assign overlap = (PX < ox_q + OW) && (ox_q < PX + PW) &&
                   (py_q < OY + OH) && (OY < py_q + PH);

  always_comb begin
    tick_d  = vs_q & ~vs_prev_q;
    state_d = state_q;
    hit_d   = hit_q;
    py_d    = py_q;
    ox_d    = ox_q;
`ifdef AUTO_RESTART_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      PLAY: begin
        if (tick_q) begin
          if (up_s2_q && !dn_s2_q)
            py_d = (py_q < PSTEP) ? 10'd0 : py_q - PSTEP;
          else if (dn_s2_q && !up_s2_q)
            py_d = (py_q > PY_MAX - PSTEP) ? PY_MAX : py_q + PSTEP;
          ox_d = (ox_q < OSTEP) ? OX_RLD : ox_q - OSTEP;
        end else if (overlap) begin
          state_d = HIT;
          hit_d   = 1'b1;
        end
      end
      HIT: begin
`ifdef AUTO_RESTART_EN
        if (tick_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = PLAY;
            hit_d   = 1'b0;
            py_d    = PY_RST;
            ox_d    = OX_RST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = PLAY;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      up_s1_q   <= 1'b1;
      up_s2_q   <= 1'b1;
      dn_s1_q   <= 1'b1;
      dn_s2_q   <= 1'b1;
      vs_q      <= 1'b1;
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
      state_q   <= PLAY;
      hit_q     <= 1'b0;
      py_q      <= PY_RST;
      ox_q      <= OX_RST;
    end else begin
      up_s1_q   <= bus.btnUp;
      up_s2_q   <= up_s1_q;
      dn_s1_q   <= bus.btnDown;
      dn_s2_q   <= dn_s1_q;
      vs_q      <= bus.vSync;
      vs_prev_q <= vs_q;
      tick_q    <= tick_d;
      state_q   <= state_d;
      hit_q     <= hit_d;
      py_q      <= py_d;
      ox_q      <= ox_d;
    end
  end

`ifdef AUTO_RESTART_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign bus.playerX   = PX;
  assign bus.playerY   = py_q;
  assign bus.obsX      = ox_q;
  assign bus.obsY      = OY;
  assign bus.hit       = hit_q;
  assign bus.frameTick = tick_q;

endmodule
